// File: rtl/divider_nbit_iter_if.sv
// Operand/result handshake bundle for divider_nbit_iter; master drives operands and out_ready.
interface divider_nbit_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Q, R, div_by_zero
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Q, R, div_by_zero
  );
endinterface

// File: rtl/divider_nbit_iter.sv
// Iterative unsigned restoring divider, one quotient bit per clock; DIVIDER_DBZ_FAST_EN skips RUN when B==0.
// Latency WIDTH+1 cycles (1 for fast divide-by-zero); result held in DONE until out_ready, in_ready only in IDLE.
module divider_nbit_iter #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  divider_nbit_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  // The WIDTH+1-bit partial remainder only exists on the shifted/trial path:
  // a restored remainder is always below the divisor, so its top bit is 0.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic             unused_trial_msb;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};

  // Trial subtract as an add of the divisor's two's complement; carry-out set means no borrow.
  assign {no_borrow, trial} = {1'b0, shifted} + {1'b0, ~{1'b0, dsr_q}} + (WIDTH + 2)'(1);
  assign unused_trial_msb   = trial[WIDTH];

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d   = bus.A;
          dsr_d   = bus.B;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = (bus.B == '0);
          state_d = RUN;
`ifdef DIVIDER_DBZ_FAST_EN
          if (bus.B == '0) begin
            dvd_d   = '1;
            rem_d   = bus.A;
            state_d = DONE;
          end
`else
`endif
        end
      end
      RUN: begin
        dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
        rem_d = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE) && !rst;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.Q           = dvd_q;
  assign bus.R           = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_nbit_iter.sv
// Directed and reference-model checks of divider_nbit_iter at WIDTH=8.
module tb_divider_nbit_iter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  divider_nbit_iter_if #(.WIDTH(W)) bus ();

  divider_nbit_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DIVIDER_DBZ_FAST_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = W + 1;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one divide with out_ready high; report result and cycles from accept to out_valid.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dbz, output int lat, output bit ok);
    int guard;
    ok = 1'b1; lat = 0; q = '0; r = '0; dbz = 1'b0; guard = 0;
    bus.out_ready = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!bus.in_ready) begin
      ok = 1'b0;
      bus.in_valid = 1'b0;
    end else begin
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 50) begin
        tick();
        lat++;
      end
      if (!bus.out_valid) begin
        ok = 1'b0;
      end else begin
        q = bus.Q;
        r = bus.R;
        dbz = bus.div_by_zero;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.Q !== 8'd0 || bus.R !== 8'd0 || bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b Q=%0d R=%0d dbz=%b want v=0 Q=0 R=0 dbz=0",
               bus.out_valid, bus.Q, bus.R, bus.div_by_zero);
    end
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready_high: got %b want 0", bus.in_ready);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready_after: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] q, r;
    logic dbz;
    int lat;
    bit ok;
    run_div(8'd100, 8'd7, q, r, dbz, lat, ok);
    n_vec++;
    if (!ok || q !== 8'd14 || r !== 8'd2 || dbz !== 1'b0) begin
      n_err++;
      $display("FAIL basic_100_7: got ok=%0d Q=%0d R=%0d dbz=%b want Q=14 R=2 dbz=0", ok, q, r, dbz);
    end
    n_vec++;
    if (lat != W + 1) begin
      n_err++;
      $display("FAIL basic_latency: got %0d want %0d", lat, W + 1);
    end
  endtask

  task automatic test_edges();
    logic [7:0] ta[3] = '{8'd255, 8'd3, 8'd0};
    logic [7:0] tb[3] = '{8'd1, 8'd200, 8'd5};
    logic [7:0] tq[3] = '{8'd255, 8'd0, 8'd0};
    logic [7:0] tr[3] = '{8'd0, 8'd3, 8'd0};
    logic [7:0] q, r;
    logic dbz;
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      run_div(ta[i], tb[i], q, r, dbz, lat, ok);
      n_vec++;
      if (!ok || q !== tq[i] || r !== tr[i] || dbz !== 1'b0) begin
        n_err++;
        $display("FAIL edge_%0d_%0d: got ok=%0d Q=%0d R=%0d dbz=%b want Q=%0d R=%0d dbz=0",
                 ta[i], tb[i], ok, q, r, dbz, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [7:0] q, r;
    logic dbz;
    int lat;
    bit ok;
    run_div(8'd5, 8'd0, q, r, dbz, lat, ok);
    n_vec++;
    if (!ok || q !== 8'd255 || r !== 8'd5 || dbz !== 1'b1) begin
      n_err++;
      $display("FAIL dbz_result: got ok=%0d Q=%0d R=%0d dbz=%b want Q=255 R=5 dbz=1", ok, q, r, dbz);
    end
    n_vec++;
    if (lat != DBZ_LAT) begin
      n_err++;
      $display("FAIL dbz_latency: got %0d want %0d", lat, DBZ_LAT);
    end
    // Following divide must clear the flag again.
    run_div(8'd9, 8'd4, q, r, dbz, lat, ok);
    n_vec++;
    if (!ok || q !== 8'd2 || r !== 8'd1 || dbz !== 1'b0) begin
      n_err++;
      $display("FAIL dbz_clear: got ok=%0d Q=%0d R=%0d dbz=%b want Q=2 R=1 dbz=0", ok, q, r, dbz);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, q, r;
    logic dbz;
    int lat;
    bit ok;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_div(a, b, q, r, dbz, lat, ok);
      n_vec++;
      if (!ok || q !== a / b || r !== a % b || dbz !== 1'b0 || lat != W + 1) begin
        n_err++;
        $display("FAIL random_%0d_%0d: got ok=%0d Q=%0d R=%0d dbz=%b lat=%0d want Q=%0d R=%0d dbz=0 lat=%0d",
                 a, b, ok, q, r, dbz, lat, a / b, a % b, W + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    logic [7:0] q, r;
    logic dbz;
    int lat;
    bit ok;
    bus.out_ready = 1'b0;
    bus.A = 8'd200;
    bus.B = 8'd9;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      tick();
      guard++;
    end
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_out_valid_timeout: got %b want 1", bus.out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.in_valid = 1'b1;
        bus.A = 8'd9;
        bus.B = 8'd3;
      end else begin
        bus.in_valid = 1'b0;
      end
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.Q !== 8'd22 || bus.R !== 8'd2 || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall_%0d: got v=%b Q=%0d R=%0d in_ready=%b want v=1 Q=22 R=2 in_ready=0",
                 i, bus.out_valid, bus.Q, bus.R, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got v=%b in_ready=%b want v=0 in_ready=1", bus.out_valid, bus.in_ready);
    end
    run_div(8'd201, 8'd10, q, r, dbz, lat, ok);
    n_vec++;
    if (!ok || q !== 8'd20 || r !== 8'd1) begin
      n_err++;
      $display("FAIL bp_after: got ok=%0d Q=%0d R=%0d want Q=20 R=1", ok, q, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa[3] = '{8'd100, 8'd255, 8'd77};
    logic [7:0] pb[3] = '{8'd7, 8'd16, 8'd77};
    logic [7:0] eq[3] = '{8'd14, 8'd15, 8'd1};
    logic [7:0] er[3] = '{8'd2, 8'd15, 8'd0};
    logic [7:0] gq[3];
    logic [7:0] gr[3];
    int acc_t[3];
    int n_acc, n_res;
    bit acc_now, res_now;
    n_acc = 0;
    n_res = 0;
    for (int i = 0; i < 3; i++) begin
      acc_t[i] = 0; gq[i] = '0; gr[i] = '0;
    end
    bus.out_ready = 1'b1;
    bus.A = pa[0];
    bus.B = pb[0];
    bus.in_valid = 1'b1;
    for (int t = 0; t < 80 && n_res < 3; t++) begin
      acc_now = bus.in_ready && bus.in_valid;
      res_now = bus.out_valid;
      if (acc_now && n_acc < 3) acc_t[n_acc] = t;
      if (res_now && n_res < 3) begin
        gq[n_res] = bus.Q;
        gr[n_res] = bus.R;
      end
      tick();
      if (acc_now && n_acc < 3) begin
        n_acc++;
        if (n_acc < 3) begin
          bus.A = pa[n_acc];
          bus.B = pb[n_acc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (res_now) n_res++;
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (n_res != 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results want 3", n_res);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (gq[i] !== eq[i] || gr[i] !== er[i]) begin
        n_err++;
        $display("FAIL b2b_result_%0d: got Q=%0d R=%0d want Q=%0d R=%0d", i, gq[i], gr[i], eq[i], er[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_vec++;
      if (acc_t[i] - acc_t[i-1] != W + 2) begin
        n_err++;
        $display("FAIL b2b_spacing_%0d: got %0d want %0d", i, acc_t[i] - acc_t[i-1], W + 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    logic [7:0] q, r;
    logic dbz;
    int lat;
    bit ok;
    bus.out_ready = 1'b1;
    bus.A = 8'd200;
    bus.B = 8'd3;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.Q !== 8'd0 || bus.R !== 8'd0 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: got v=%b Q=%0d R=%0d in_ready=%b want v=0 Q=0 R=0 in_ready=0",
               bus.out_valid, bus.Q, bus.R, bus.in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    run_div(8'd50, 8'd6, q, r, dbz, lat, ok);
    n_vec++;
    if (!ok || q !== 8'd8 || r !== 8'd2 || dbz !== 1'b0 || lat != W + 1) begin
      n_err++;
      $display("FAIL rst_then_50_6: got ok=%0d Q=%0d R=%0d dbz=%b lat=%0d want Q=8 R=2 dbz=0 lat=%0d",
               ok, q, r, dbz, lat, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_by_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
